// File: rtl/pcap_replay_mem_reader_pkg.sv
// Shared definitions for the pcap replay read engine: FSM encoding and
// memory entry field positions.
//
// Entry layout (MEM_DATA_WIDTH = 1 + DW/8 + DW bits):
//   [DW+DW/8]        kind: 1 = header, 0 = data
//   header: [TUSER-1:0] carries the tuser value for the following packet
//   data:   [DW+DW/8-1:DW] tstrb, [DW-1:0] tdata
// The entry word has no spare bit beside the kind bit, so a data beat is
// marked last by clearing the top tstrb bit (a partial final beat).
package pcap_replay_mem_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  function automatic int mem_data_width(input int dw);
    return 1 + dw / 8 + dw;
  endfunction

  // Position of the header/data kind bit (the entry MSB).
  function automatic int kind_bit(input int dw);
    return dw + dw / 8;
  endfunction

  // Bit whose clear state marks the last beat of a packet (tstrb MSB).
  function automatic int tlast_bit(input int dw);
    return dw + dw / 8 - 1;
  endfunction

  // Lowest bit of the tstrb field; tdata sits below it.
  function automatic int strb_lsb(input int dw);
    return dw;
  endfunction

endpackage

// File: rtl/pcap_replay_resp_fifo.sv
// First-word-fall-through response FIFO with occupancy count. The head
// entry is visible on dout whenever empty is low.
module pcap_replay_resp_fifo #(
  parameter int WIDTH      = 289,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  clk,
  input  logic                  srst,
  input  logic                  push,
  input  logic [WIDTH-1:0]      din,
  input  logic                  pop,
  output logic [WIDTH-1:0]      dout,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0]      mem_arr [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_reg;
  logic [DEPTH_LOG2-1:0] rd_ptr_reg;
  logic [DEPTH_LOG2:0]   count_reg;
  logic                  full;
  logic                  do_push;
  logic                  do_pop;

  assign full    = count_reg[DEPTH_LOG2];
  assign empty   = (count_reg == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem_arr[rd_ptr_reg];
  assign count   = count_reg;

  // Storage write; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_arr[wr_ptr_reg] <= din;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/pcap_replay_mem_reader.sv
// Read side of the pcap replay engine: walks packet memory entries
// 0..mem_addr_high-1 for replay_count passes and replays data entries on
// m_axis, tagging each beat with the tuser of the latest header entry.
// Optional statistics (pkt_count, hdr_err) are built when the macro
// PCAP_REPLAY_READER_STATS_EN is defined.
module pcap_replay_mem_reader
  import pcap_replay_mem_reader_pkg::*;
#(
  parameter int C_M_AXIS_DATA_WIDTH  = 256,
  parameter int C_M_AXIS_TUSER_WIDTH = 128,
  parameter int MEM_ADDR_WIDTH       = 19,
  parameter int REPLAY_COUNT_WIDTH   = 32,
  parameter int FIFO_DEPTH_LOG2      = 3,
  localparam int MEM_DATA_WIDTH      = mem_data_width(C_M_AXIS_DATA_WIDTH)
) (
  input  logic                              axi_aclk,
  input  logic                              reset,
  input  logic                              start_replay,
  input  logic [MEM_ADDR_WIDTH-1:0]         mem_addr_high,
  input  logic [REPLAY_COUNT_WIDTH-1:0]     replay_count,
  output logic                              mem_rd_req,
  output logic [MEM_ADDR_WIDTH-1:0]         mem_rd_addr,
  input  logic                              mem_rd_gnt,
  input  logic                              mem_rd_valid,
  input  logic [MEM_DATA_WIDTH-1:0]         mem_rd_data,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                              m_axis_tvalid,
  input  logic                              m_axis_tready,
  output logic                              m_axis_tlast,
  output logic                              busy,
  output logic                              done
`ifdef PCAP_REPLAY_READER_STATS_EN
  ,
  output logic [31:0]                       pkt_count,
  output logic                              hdr_err
`endif
);

  localparam int DW        = C_M_AXIS_DATA_WIDTH;
  localparam int TW        = C_M_AXIS_TUSER_WIDTH;
  localparam int AW        = MEM_ADDR_WIDTH;
  localparam int RW        = REPLAY_COUNT_WIDTH;
  localparam int KIND_BIT  = kind_bit(DW);
  localparam int TLAST_BIT = tlast_bit(DW);
  localparam int STRB_LSB  = strb_lsb(DW);

  state_t                 state_reg;
  logic                   start_prev_reg;
  logic [AW-1:0]          high_reg;
  logic [RW-1:0]          count_reg;
  logic [AW-1:0]          addr_reg;
  logic [RW-1:0]          pass_reg;
  // Reads granted but not yet popped from the FIFO (in flight + stored).
  logic [FIFO_DEPTH_LOG2:0] pending_reg;
  logic [TW-1:0]          tuser_reg;

  logic                   start_edge;
  logic                   grant;
  logic                   fifo_push;
  logic [MEM_DATA_WIDTH-1:0] fifo_dout;
  logic                   fifo_empty;
  logic [FIFO_DEPTH_LOG2:0] fifo_count;
  logic                   head_is_hdr;
  logic                   out_free;
  logic                   pop_hdr;
  logic                   pop_data;
  logic                   pop;

  assign start_edge  = start_replay && !start_prev_reg;
  // pending_reg never exceeds the FIFO depth, so its MSB set means no credit left.
  assign mem_rd_req  = (state_reg == ST_RUN) && !pending_reg[FIFO_DEPTH_LOG2];
  assign mem_rd_addr = addr_reg;
  assign grant       = mem_rd_req && mem_rd_gnt;
  assign busy        = (state_reg == ST_RUN) || (state_reg == ST_DRAIN);
  assign done        = (state_reg == ST_DONE);

  // Only responses belonging to a live run are stored.
  assign fifo_push   = mem_rd_valid && busy;
  assign head_is_hdr = fifo_dout[KIND_BIT];
  assign out_free    = !m_axis_tvalid || m_axis_tready;
  assign pop_hdr     = !fifo_empty && head_is_hdr;
  assign pop_data    = !fifo_empty && !head_is_hdr && out_free;
  assign pop         = pop_hdr || pop_data;

  pcap_replay_resp_fifo #(
    .WIDTH      (MEM_DATA_WIDTH),
    .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
  ) u_resp_fifo (
    .clk   (axi_aclk),
    .srst  (reset),
    .push  (fifo_push),
    .din   (mem_rd_data),
    .pop   (pop),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Run control: start latching, address walk, pass counting and state.
  always_ff @(posedge axi_aclk) begin
    if (reset) begin
      state_reg      <= ST_IDLE;
      start_prev_reg <= 1'b0;
      high_reg       <= '0;
      count_reg      <= '0;
      addr_reg       <= '0;
      pass_reg       <= '0;
    end else begin
      start_prev_reg <= start_replay;
      case (state_reg)
        ST_IDLE: begin
          if (start_edge) begin
            high_reg  <= mem_addr_high;
            count_reg <= replay_count;
            addr_reg  <= '0;
            pass_reg  <= '0;
            if (mem_addr_high == '0 || replay_count == '0) begin
              state_reg <= ST_DONE;
            end else begin
              state_reg <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (grant) begin
            if (addr_reg == high_reg - AW'(1)) begin
              addr_reg <= '0;
              pass_reg <= pass_reg + RW'(1);
              if (pass_reg == count_reg - RW'(1)) begin
                state_reg <= ST_DRAIN;
              end
            end else begin
              addr_reg <= addr_reg + AW'(1);
            end
          end
        end
        ST_DRAIN: begin
          if (pending_reg == '0 && fifo_count == '0 && !m_axis_tvalid) begin
            state_reg <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (!start_replay) begin
            state_reg <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  // Credit tracking: a grant takes a FIFO slot, a FIFO pop returns it.
  always_ff @(posedge axi_aclk) begin
    if (reset) begin
      pending_reg <= '0;
    end else begin
      case ({grant, pop})
        2'b10:   pending_reg <= pending_reg + 1'b1;
        2'b01:   pending_reg <= pending_reg - 1'b1;
        default: pending_reg <= pending_reg;
      endcase
    end
  end

  // Output register: headers update tuser_reg, data entries become beats
  // that are held unchanged until accepted.
  always_ff @(posedge axi_aclk) begin
    if (reset) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tstrb  <= '0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= '0;
      tuser_reg     <= '0;
    end else begin
      if (m_axis_tvalid && m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
      if (pop_data) begin
        m_axis_tvalid <= 1'b1;
        m_axis_tdata  <= fifo_dout[DW-1:0];
        m_axis_tstrb  <= fifo_dout[KIND_BIT-1:STRB_LSB];
        m_axis_tlast  <= !fifo_dout[TLAST_BIT];
        m_axis_tuser  <= tuser_reg;
      end
      if (pop_hdr) begin
        tuser_reg <= fifo_dout[TW-1:0];
      end
    end
  end

`ifdef PCAP_REPLAY_READER_STATS_EN
  logic hdr_seen_reg;

  // Packet counter and missing-header detector.
  always_ff @(posedge axi_aclk) begin
    if (reset) begin
      pkt_count    <= '0;
      hdr_err      <= 1'b0;
      hdr_seen_reg <= 1'b0;
    end else begin
      if (state_reg == ST_IDLE && start_edge) begin
        pkt_count <= '0;
      end else if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
        pkt_count <= pkt_count + 32'd1;
      end
      if (pop_hdr) begin
        hdr_seen_reg <= 1'b1;
      end else if (pop_data) begin
        if (!hdr_seen_reg) hdr_err <= 1'b1;
        if (!fifo_dout[TLAST_BIT]) hdr_seen_reg <= 1'b0;
      end
    end
  end
`endif

endmodule
